// File: rtl/div_pipe_pkg.sv
// Shared math-layer helpers for the pipelined divider: latency and configuration legality.
package div_pipe_pkg;

    // Total register depth: input stage, one register per division stage, output stage.
    function automatic int div_lat(input int div_w, input int bps);
        return div_w / bps + 2;
    endfunction

    function automatic bit div_cfg_ok(input int div_w, input int bps);
        return (div_w >= 2) && (bps == 1 || bps == 2 || bps == 4) && (div_w % bps == 0);
    endfunction

endpackage

// File: rtl/div_pipe_stage.sv
// One combinational restoring-division step that resolves BPS quotient bits, MSB first.
module div_pipe_stage #(
    parameter int DIV_W = 24,
    parameter int BPS   = 1
) (
    input  logic [DIV_W-1:0] rem_in,
    input  logic [DIV_W-1:0] divisor,
    input  logic [DIV_W-1:0] dq_in,
    output logic [DIV_W-1:0] rem_out,
    output logic [DIV_W-1:0] dq_out
);

    // dq holds the unconsumed dividend bits at the top and the quotient bits
    // collected so far at the bottom; each step shifts one bit across.
    logic [DIV_W:0]   acc;
    logic [DIV_W-1:0] rem_v;
    logic [DIV_W-1:0] dq_v;

    always_comb begin
        acc   = '0;
        rem_v = rem_in;
        dq_v  = dq_in;
        for (int i = 0; i < BPS; i++) begin
            acc  = {rem_v, dq_v[DIV_W-1]};
            dq_v = {dq_v[DIV_W-2:0], 1'b0};
            if (acc >= {1'b0, divisor}) begin
                acc     = acc - {1'b0, divisor};
                dq_v[0] = 1'b1;
            end
            rem_v = acc[DIV_W-1:0];
        end
        rem_out = rem_v;
        dq_out  = dq_v;
    end

endmodule

// File: rtl/div_pipe.sv
// Fully pipelined integer divider with global-stall valid/ready flow control and tag passthrough.
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter int DIV_W  = 24,
    parameter int BPS    = 1,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r,
    output logic             dz,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = DIV_W / BPS;

    if (!div_cfg_ok(DIV_W, BPS)) begin : g_cfg_err
        $error("div_pipe: DIV_W=%0d with BPS=%0d is not supported", DIV_W, BPS);
    end

    // Handshake: an input transfers when in_valid && in_ready, an output when
    // out_valid && out_ready; a held output freezes every pipeline register.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic             sign_a, sign_b;
    logic [DIV_W-1:0] mag_a, mag_b;
    logic [DIV_W-1:0] q_fix, r_fix;

    logic [N:0]       v_q, nq_q, sa_q, dz_q;
    logic [DIV_W-1:0] rem_q [0:N];
    logic [DIV_W-1:0] dq_q  [0:N];
    logic [DIV_W-1:0] dv_q  [0:N-1];
    logic [TAG_W-1:0] tag_q [0:N];
    logic [DIV_W-1:0] rem_nx [0:N-1];
    logic [DIV_W-1:0] dq_nx  [0:N-1];

    // With a zero divisor every step subtracts nothing, so the final remainder
    // is |a| and the quotient is all ones; only the sign of r needs restoring.
    always_comb begin
        sign_a = (SIGNED != 0) && a[DIV_W-1];
        sign_b = (SIGNED != 0) && b[DIV_W-1];
        mag_a  = sign_a ? (~a + DIV_W'(1)) : a;
        mag_b  = sign_b ? (~b + DIV_W'(1)) : b;
        q_fix  = dz_q[N] ? '1 : (nq_q[N] ? (~dq_q[N] + DIV_W'(1)) : dq_q[N]);
        r_fix  = sa_q[N] ? (~rem_q[N] + DIV_W'(1)) : rem_q[N];
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        div_pipe_stage #(.DIV_W(DIV_W), .BPS(BPS)) u_stage (
            .rem_in  (rem_q[k]),
            .divisor (dv_q[k]),
            .dq_in   (dq_q[k]),
            .rem_out (rem_nx[k]),
            .dq_out  (dq_nx[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dz        <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            v_q[0]   <= in_valid;
            nq_q[0]  <= sign_a ^ sign_b;
            sa_q[0]  <= sign_a;
            dz_q[0]  <= (b == '0);
            tag_q[0] <= in_tag;
            rem_q[0] <= '0;
            dq_q[0]  <= mag_a;
            dv_q[0]  <= mag_b;
            for (int k = 1; k <= N; k++) begin
                v_q[k]   <= v_q[k-1];
                nq_q[k]  <= nq_q[k-1];
                sa_q[k]  <= sa_q[k-1];
                dz_q[k]  <= dz_q[k-1];
                tag_q[k] <= tag_q[k-1];
                rem_q[k] <= rem_nx[k-1];
                dq_q[k]  <= dq_nx[k-1];
            end
            for (int k = 1; k < N; k++) begin
                dv_q[k] <= dv_q[k-1];
            end
            out_valid <= v_q[N];
            if (v_q[N]) begin
                q       <= q_fix;
                r       <= r_fix;
                dz      <= dz_q[N];
                out_tag <= tag_q[N];
            end
        end
    end

endmodule

// File: tb/tb_div_pipe.sv
// Self-checking bench for div_pipe: directed vectors, streaming with backpressure, reset flush, 8-bit sweep.
module tb_div_pipe;

    localparam int NDUT = 4;
    localparam int BPS_T [NDUT] = '{1, 1, 2, 4};
    localparam int SGN_T [NDUT] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NDUT-1:0] iv, ordy;
    wire  [NDUT-1:0] ir, ov, dz_s;
    logic [23:0] a_s [NDUT];
    logic [23:0] b_s [NDUT];
    logic [7:0]  tag_s [NDUT];
    wire  [23:0] q_s [NDUT];
    wire  [23:0] r_s [NDUT];
    wire  [7:0]  otag [NDUT];

    logic       iv8, ordy8;
    wire        ir8, ov8, dz8;
    logic [7:0] a8, b8, t8;
    wire  [7:0] q8, r8, ot8;

    int n_pass = 0;
    int n_total = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        div_pipe #(.DIV_W(24), .BPS(BPS_T[g]), .SIGNED(SGN_T[g]), .TAG_W(8)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a_s[g]), .b(b_s[g]), .in_tag(tag_s[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .q(q_s[g]), .r(r_s[g]), .dz(dz_s[g]), .out_tag(otag[g])
        );
    end

    div_pipe #(.DIV_W(8), .BPS(1), .SIGNED(0), .TAG_W(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .in_tag(t8),
        .out_valid(ov8), .out_ready(ordy8),
        .q(q8), .r(r8), .dz(dz8), .out_tag(ot8)
    );

    typedef struct {
        int          d;
        logic [23:0] a;
        logic [23:0] b;
        logic [7:0]  tag;
        logic [23:0] q;
        logic [23:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [48:0] model24(input logic [23:0] av, input logic [23:0] bv, input bit sgn);
        longint sa, sb, qq, rr;
        if (bv == 24'd0) return {24'hFFFFFF, av, 1'b1};
        if (sgn) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
        end else begin
            sa = longint'({40'd0, av});
            sb = longint'({40'd0, bv});
        end
        qq = sa / sb;
        rr = sa % sb;
        return {qq[23:0], rr[23:0], 1'b0};
    endfunction

    function automatic logic [16:0] model8(input logic [7:0] av, input logic [7:0] bv);
        if (bv == 8'd0) return {8'hFF, av, 1'b1};
        return {av / bv, av % bv, 1'b0};
    endfunction

    // Single op with out_ready high; lat counts rising edges from the accepting edge (=1).
    task automatic run_single(input int d, input logic [23:0] av, input logic [23:0] bv,
                              input logic [7:0] tv, output logic [56:0] res, output int lat);
        @(negedge clk);
        ordy[d]  = 1'b1;
        iv[d]    = 1'b1;
        a_s[d]   = av;
        b_s[d]   = bv;
        tag_s[d] = tv;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) iv[d] = 1'b0;
        end while (!ov[d] && lat < 100);
        res = {q_s[d], r_s[d], dz_s[d], otag[d]};
    endtask

    task automatic stream(input int d, input int nops);
        logic [56:0] exp_q [$];
        logic [56:0] held, act;
        logic [31:0] rnd;
        bit pend, stalled_prev;
        int sent, got;
        sent = 0; got = 0; pend = 0; stalled_prev = 0; held = '0;
        for (int cyc = 0; cyc < 3000 && got < nops; cyc++) begin
            @(negedge clk);
            ordy[d] = ($urandom_range(0, 3) != 0);
            if (!pend && sent < nops && $urandom_range(0, 4) != 0) begin
                rnd = $urandom;
                a_s[d] = rnd[23:0];
                rnd = $urandom;
                if ($urandom_range(0, 9) == 0) b_s[d] = 24'd0;
                else if ($urandom_range(0, 1) == 0) b_s[d] = rnd[23:0];
                else b_s[d] = 24'($urandom_range(1, 300));
                tag_s[d] = sent[7:0];
                iv[d] = 1'b1;
                pend = 1;
            end else if (!pend) begin
                iv[d] = 1'b0;
            end
            #1;
            act = {q_s[d], r_s[d], dz_s[d], otag[d]};
            check("in_ready_vs_stall", 64'(ir[d]), 64'(!(ov[d] && !ordy[d])));
            if (stalled_prev) check("stall_hold", 64'(act), 64'(held));
            if (ov[d] && ordy[d]) begin
                check("result_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) check("stream_result", 64'(act), 64'(exp_q.pop_front()));
                got++;
            end
            stalled_prev = ov[d] && !ordy[d];
            held = act;
            if (iv[d] && ir[d]) begin
                exp_q.push_back({model24(a_s[d], b_s[d], SGN_T[d] != 0), tag_s[d]});
                sent++;
                pend = 0;
            end
        end
        @(negedge clk);
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        check("stream_count", 64'(got), 64'(nops));
    endtask

    initial begin
        logic [56:0] res;
        logic [24:0] exp8_q [$];
        int lat, n_seen, first_out, got8;

        vecs[0]  = '{0, 24'd1000,    24'd7,       8'h5A, 24'd142,     24'd6,       1'b0};
        vecs[1]  = '{0, 24'd5,       24'd0,       8'h11, 24'hFFFFFF,  24'd5,       1'b1};
        vecs[2]  = '{0, 24'd9,       24'd3,       8'h12, 24'd3,       24'd0,       1'b0};
        vecs[3]  = '{1, 24'hFFFFF9,  24'd2,       8'h21, 24'hFFFFFD,  24'hFFFFFF,  1'b0};
        vecs[4]  = '{1, 24'd7,       24'hFFFFFE,  8'h22, 24'hFFFFFD,  24'd1,       1'b0};
        vecs[5]  = '{1, 24'h800000,  24'hFFFFFF,  8'h23, 24'h800000,  24'd0,       1'b0};
        vecs[6]  = '{1, 24'hFFFFFB,  24'd0,       8'h24, 24'hFFFFFF,  24'hFFFFFB,  1'b1};
        vecs[7]  = '{2, 24'd1000,    24'd7,       8'h31, 24'd142,     24'd6,       1'b0};
        vecs[8]  = '{2, 24'hFFFFFF,  24'd1,       8'h32, 24'hFFFFFF,  24'd0,       1'b0};
        vecs[9]  = '{3, 24'h800000,  24'd3,       8'h41, 24'h2AAAAA,  24'd2,       1'b0};
        vecs[10] = '{3, 24'd100,     24'd10,      8'h42, 24'd10,      24'd0,       1'b0};
        vecs[11] = '{0, 24'hFFFFFF,  24'hFFFFFF,  8'h13, 24'd1,       24'd0,       1'b0};
        vecs[12] = '{0, 24'd12,      24'd24,      8'h14, 24'd0,       24'd12,      1'b0};
        vecs[13] = '{1, 24'hFFFFF8,  24'hFFFFFD,  8'h25, 24'd2,       24'hFFFFFE,  1'b0};
        vecs[14] = '{2, 24'd0,       24'd0,       8'h33, 24'hFFFFFF,  24'd0,       1'b1};
        vecs[15] = '{3, 24'hABCDEF,  24'h000010,  8'h43, 24'h0ABCDE,  24'h00000F,  1'b0};

        rst = 1'b1;
        iv = '0;
        ordy = '1;
        iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; t8 = '0;
        for (int d = 0; d < NDUT; d++) begin
            a_s[d] = '0; b_s[d] = '0; tag_s[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_out_valid", 64'(ov[d]), 64'(0));
            check("reset_outputs", 64'({q_s[d], r_s[d], dz_s[d], otag[d]}), 64'(0));
        end
        check("reset8_outputs", 64'({ov8, q8, r8, dz8, ot8}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 64'({ir8, ir}), 64'(5'b11111));

        for (int i = 0; i < 16; i++) begin
            run_single(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].tag, res, lat);
            check($sformatf("vec%0d_result", i), 64'(res),
                  64'({vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].tag}));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(24 / BPS_T[vecs[i].d] + 2));
        end

        stream(0, 100);
        stream(1, 100);

        // Ten ops in flight, then a one-cycle reset that also coincides with in_valid.
        @(negedge clk);
        ordy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'b1;
            a_s[0] = 24'(1000 + i);
            b_s[0] = 24'd3;
            tag_s[0] = 8'(i);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        iv[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        iv[0] = 1'b0;
        n_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov[0]) n_seen++;
        end
        check("reset_flush", 64'(n_seen), 64'(0));
        run_single(0, 24'd100, 24'd10, 8'hC3, res, lat);
        check("post_reset_result", 64'(res), 64'({24'd10, 24'd0, 1'b0, 8'hC3}));
        check("post_reset_latency", 64'(lat), 64'(26));

        first_out = -1;
        got8 = 0;
        for (int it = 0; it < 65536 + 20; it++) begin
            @(negedge clk);
            if (it < 65536) begin
                iv8 = 1'b1;
                a8 = it[15:8];
                b8 = it[7:0];
                t8 = it[15:8] ^ it[7:0];
            end else begin
                iv8 = 1'b0;
            end
            #1;
            if (ov8) begin
                if (first_out < 0) first_out = it;
                check("sweep8_expected", 64'(exp8_q.size() != 0), 64'(1));
                if (exp8_q.size() != 0) check("sweep8_result", 64'({q8, r8, dz8, ot8}), 64'(exp8_q.pop_front()));
                got8++;
            end
            if (iv8 && ir8) exp8_q.push_back({model8(a8, b8), t8});
        end
        check("sweep8_latency", 64'(first_out), 64'(10));
        check("sweep8_count", 64'(got8), 64'(65536));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_pipe.md
# div_pipe

Parametrised, fully pipelined integer divider with valid/ready flow control, optional signed mode, a divide-by-zero flag and a user tag carried alongside each operation. It accepts one division per cycle and produces quotient and remainder after a fixed latency. It sits in the tracker's math layer beside the centroid/ratio computations, which need per-result tags and backpressure from downstream consumers.

## Interface
- DIV_W, 24, operand/result width in bits (≥2)
- BPS, 1, quotient bits resolved per pipeline stage; must divide DIV_W evenly (1, 2, 4 supported)
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
- TAG_W, 8, width of the opaque tag passed through with each operation
- clk  in  1  clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept; a transfer happens when in_valid && in_ready
- a  in  DIV_W  dividend
- b  in  DIV_W  divisor
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; a transfer happens when out_valid && out_ready
- q  out  DIV_W  quotient
- r  out  DIV_W  remainder
- dz  out  1  divisor was zero
- out_tag  out  TAG_W  tag of this result

## Operation
- Stages: input register (S0) captures magnitudes |a| and |b|, sign info, the zero flag and the tag. It is followed by N = DIV_W/BPS restoring-division stages, each resolving BPS quotient bits MSB-first with shift/compare/subtract. The output register (S_OUT) then applies sign fixup and special cases.
- Unsigned: q = a / b, r = a % b.
- Signed: quotients truncate toward zero. The quotient is negated when the operand signs differ; the remainder takes the sign of a. Most-negative / −1 gives q = most-negative, r = 0; this is the natural wrap, with no flag.
- b == 0, any mode: q = all ones, r = a (original, not magnitude), dz = 1. Otherwise dz = 0.
- Internal remainder accumulator is DIV_W+1 bits. A 2^(DIV_W−1) magnitude must not overflow.
- Every stage carries a valid bit, tag, dz, and sign bits in lockstep with the data.
- Flow control is a global stall: stall = out_valid && !out_ready. When stalled, no pipeline register changes, and in_ready = !stall.
- Bubbles: stages with valid = 0 advance normally. Their data contents are don't-care.

## Timing
- Latency: N+2 cycles from the accepting edge to out_valid, with no stalls. DIV_W=24, BPS=1 gives 26; BPS=4 gives 8.
- Throughput: one result per cycle while out_ready = 1.
- in_ready is combinational from out_valid/out_ready. It is the only combinational in→out path.
- q, r, dz and out_tag hold stable while out_valid && !out_ready.
- Reset: every stage valid bit clears to 0, so out_valid = 0. q, r, dz and out_tag reset to 0. in_ready = 1 in the cycle after reset is released.
- Reset mid-operation discards all in-flight operations. No results are emitted for them.
- Reset asserted in the same cycle as in_valid: the operation is not accepted.
- out_ready deasserted for k cycles delays each in-flight result by exactly k cycles. Nothing is lost or duplicated.

## Structure
- The shared math package holds a latency function div_lat(DIV_W, BPS) = DIV_W/BPS + 2, so consumers can size tag FIFOs and delay lines.
- The package also holds the DIV_W/BPS legality check, an elaboration-time error.
- One sub-module, div_pipe_stage: a combinational BPS-bit restoring step (remainder, divisor, partial quotient in; updated remainder and quotient out). div_pipe instantiates it N times via generate and owns all registers and flow control.

## Test plan
- Unsigned, DIV_W=24, BPS=1, out_ready=1: a=1000, b=7, tag=0x5A -> after 26 cycles q=142, r=6, dz=0, out_tag=0x5A.
- SIGNED=1: a=−7, b=2 -> q=−3, r=−1. a=7, b=−2 -> q=−3, r=1. a=0x800000, b=−1 -> q=0x800000, r=0.
- Divide by zero: a=5, b=0 -> q=0xFFFFFF, r=5, dz=1. The next op, 9/3, returns q=3, r=0, dz=0.
- Streaming plus backpressure: 100 back-to-back random ops with out_ready randomly toggled. Every result must match the reference model in order with the matching tag. in_ready must be low exactly while stalled, and outputs must be stable during stalls.
- Reset mid-flight: issue 10 ops, assert rst for 1 cycle at cycle 5 -> zero results emerge. A post-reset op, 100/10, returns q=10 after exactly N+2 cycles.
- Parameter sweep: BPS=2 and BPS=4 at DIV_W=24, and DIV_W=8 at BPS=1 (exhaustive a, b). Results are bit-exact with latency div_lat().
